// File: rtl/cpu_types_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared instruction-cache types: geometry constants, the
//               responder state type and the packed frame layout.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int ICACHE_SETS   = 16;
    localparam int ICACHE_WORD_W = 32;
    localparam int ICACHE_IDX_W  = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W  = ICACHE_WORD_W - ICACHE_IDX_W - 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic                     valid;
        logic [ICACHE_TAG_W-1:0]  tag;
        logic [ICACHE_WORD_W-1:0] data;
    } icache_frame_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/icache_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : icache_responder_if
// Description : Fetch-port and memory-port signals of the instruction cache.
//               slave = cache side, master = datapath/memory environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_responder_if #(
    parameter int WORD_W = 32
);
    logic              imemREN;
    logic [WORD_W-1:0] imemaddr;
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              flush;
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface : icache_responder_if
`default_nettype wire

// File: rtl/icache_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : icache_responder
// Description : Direct-mapped, one-word-block instruction cache. Hits answer
//               combinationally; misses fetch through the memory handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_responder
    import cpu_types_pkg::*;
#(
    parameter int SETS   = ICACHE_SETS,
    parameter int WORD_W = ICACHE_WORD_W
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    icache_responder_if.slave bus,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_W = WORD_W - c_IDX_W - 2;

    icache_frame_t     r_frames [SETS];
    icache_state_t     r_state;
    icache_state_t     w_state_next;
    logic [WORD_W-1:0] r_miss_addr;
    logic [31:0]       r_hit_cnt;
    logic [31:0]       r_miss_cnt;

    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic [c_IDX_W-1:0] w_miss_idx;
    logic [c_TAG_W-1:0] w_miss_tag;
    icache_frame_t      w_frame;
    logic               w_hit;
    logic               w_miss;
    logic               w_fill;

    assign w_idx      = bus.imemaddr[c_IDX_W+1:2];
    assign w_tag      = bus.imemaddr[WORD_W-1:c_IDX_W+2];
    assign w_miss_idx = r_miss_addr[c_IDX_W+1:2];
    assign w_miss_tag = r_miss_addr[WORD_W-1:c_IDX_W+2];
    assign w_frame    = r_frames[w_idx];

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    // Hit/miss decode, next state and port outputs. Lookups only happen in
    // IDLE, so ihit can never rise while a fill is outstanding.
    always_comb begin
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        w_fill       = 1'b0;
        w_state_next = r_state;
        bus.ihit     = 1'b0;
        bus.imemload = '0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        case (r_state)
            IDLE: begin
                if (bus.imemREN) begin
                    if (w_frame.valid && (w_frame.tag == w_tag)) begin
                        w_hit        = 1'b1;
                        bus.ihit     = 1'b1;
                        bus.imemload = w_frame.data;
                    end else begin
                        w_miss       = 1'b1;
                        w_state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                bus.iREN  = 1'b1;
                bus.iaddr = r_miss_addr;
                if (!bus.iwait) begin
                    w_fill       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The miss address is held for the whole fetch so that the fill lands in
    // the right frame even if the datapath moves on.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_miss_addr <= '0;
        end else if (w_miss) begin
            r_miss_addr <= {bus.imemaddr[WORD_W-1:2], 2'b00};
        end
    end

    // Flush is applied after the fill so a coincident flush leaves it invalid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SETS; i++) begin
                r_frames[i].valid <= 1'b0;
            end
        end else begin
            if (w_fill) begin
                r_frames[w_miss_idx] <= '{valid: 1'b1, tag: w_miss_tag, data: bus.iload};
            end
            if (bus.flush) begin
                for (int i = 0; i < SETS; i++) begin
                    r_frames[i].valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

endmodule : icache_responder
`default_nettype wire
